// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, imem request/response handshake, in-order {instr, pc} buffer, redirect flush.
// Optional misaligned-redirect trap when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] W_DEPTH = (CW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  logic [31:0]   r_fpc;
  logic [31:0]   r_pcq [DEPTH];
  logic [AW-1:0] r_pcq_wp, r_pcq_rp;
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc [DEPTH];
  logic [AW-1:0] r_buf_wp, r_buf_rp;
  logic [CW-1:0] r_count, r_outstanding, r_drop;
  logic          r_halted, r_misalign;

  logic [CW:0]   w_sum;
  logic          w_req_fire, w_rsp, w_rsp_keep, w_pop, w_misalign;
  logic [CW-1:0] w_count_nxt, w_out_nxt, w_drop_nxt;

  // Credit covers both buffered and in-flight words, so responses never need backpressure.
  assign w_sum          = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid = rst_n & ~redirect & ~r_halted & (w_sum < W_DEPTH);
  assign imem_req_addr  = r_fpc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign w_rsp          = imem_rsp_valid;
  assign w_rsp_keep     = w_rsp & (r_drop == '0) & ~redirect;
  assign instr_valid    = rst_n & (r_count != '0);
  assign w_pop          = instr_valid & instr_ready;
  assign w_misalign     = MISALIGN_EN & redirect & (redirect_pc[1:0] != 2'b00);

  assign instr        = r_buf_instr[r_buf_rp];
  assign instr_pc     = r_buf_pc[r_buf_rp];
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign misalign_err = r_misalign;

  // Counter next-state; a redirect turns every still-pending response into a drop.
  always_comb begin
    w_count_nxt = r_count;
    w_drop_nxt  = r_drop;
    w_out_nxt   = r_outstanding + CW'(w_req_fire) - CW'(w_rsp);
    if (redirect) begin
      w_count_nxt = '0;
      w_drop_nxt  = r_outstanding - CW'(w_rsp);
    end else begin
      w_count_nxt = r_count + CW'(w_rsp_keep) - CW'(w_pop);
      if (w_rsp && (r_drop != '0)) begin
        w_drop_nxt = r_drop - CW'(1'b1);
      end else begin
        w_drop_nxt = r_drop;
      end
    end
  end

  // Control state: PC, queue pointers, counters, halt/error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fpc         <= RESET_PC;
      r_pcq_wp      <= '0;
      r_pcq_rp      <= '0;
      r_buf_wp      <= '0;
      r_buf_rp      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_halted      <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_out_nxt;
      r_drop        <= w_drop_nxt;
      if (redirect) begin
        r_fpc <= {redirect_pc[31:2], 2'b00};
      end else if (w_req_fire) begin
        r_fpc <= r_fpc + 32'd4;
      end
      if (w_req_fire) begin
        r_pcq_wp <= r_pcq_wp + AW'(1'b1);
      end
      if (w_rsp) begin
        r_pcq_rp <= r_pcq_rp + AW'(1'b1);
      end
      if (redirect) begin
        r_buf_rp <= r_buf_wp;
      end else begin
        if (w_pop) begin
          r_buf_rp <= r_buf_rp + AW'(1'b1);
        end
        if (w_rsp_keep) begin
          r_buf_wp <= r_buf_wp + AW'(1'b1);
        end
      end
      if (w_misalign) begin
        r_halted   <= 1'b1;
        r_misalign <= 1'b1;
      end
    end
  end

  // Queue storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pcq[r_pcq_wp] <= r_fpc;
    end
    if (w_rsp_keep) begin
      r_buf_instr[r_buf_wp] <= imem_rsp_data;
      r_buf_pc[r_buf_wp]    <= r_pcq[r_pcq_rp];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a fixed-latency memory model returns ~addr as the instruction word,
// directed tests push expected PCs, and a separate monitor checks every consumed instruction.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .misalign_err(misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] req_exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int lat = 1;
  int req_cnt = 0;
  int pop_cnt = 0;
  logic s_req_valid, s_instr_valid, s_misalign;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: memory answers, handshake sampled mid-cycle, return just after the edge.
  task automatic tick();
    logic [31:0] a;
    if (!rst_n) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
    end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mem_q[0].addr;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    #1;
    s_req_valid   = imem_req_valid;
    s_instr_valid = instr_valid;
    s_misalign    = misalign_err;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      req_cnt++;
      if (req_exp_q.size() > 0) begin
        a = req_exp_q.pop_front();
        check32("req_addr", imem_req_addr, a);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_pops(input int n, input int budget);
    int tgt;
    int b;
    tgt = pop_cnt + n;
    b = 0;
    while (pop_cnt < tgt && b < budget) begin
      tick();
      b++;
    end
    check32("pop_timeout", 32'(pop_cnt >= tgt), 32'd1);
  endtask

  task automatic end_test(input string name);
    check32({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check32({name, "_req_left"}, 32'(req_exp_q.size()), 32'd0);
    exp_q.delete();
    req_exp_q.delete();
    rst_n = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    repeat (2) tick();
  endtask

  // Monitor: every consumed instruction is compared against the head of the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && instr_valid && instr_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check32("extra_instr_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check32("instr_pc", instr_pc, e);
          check32("instr", instr, ~e);
          check32("opcode", {25'd0, opcode}, {25'd0, ~e[6:0]});
          check32("funct3", {29'd0, funct3}, {29'd0, ~e[14:12]});
          check32("funct7", {25'd0, funct7}, {25'd0, ~e[31:25]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int r0;
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0000_0000;
    redirect = 1'b0;
    redirect_pc = 32'h0000_0000;
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    check32("rst_req_valid", 32'(s_req_valid), 32'd0);
    check32("rst_instr_valid", 32'(s_instr_valid), 32'd0);
    check32("rst_misalign", 32'(s_misalign), 32'd0);

    // T1: 1-cycle memory, continuous consumption
    lat = 1;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) req_exp_q.push_back(32'(i * 4));
    p0 = pop_cnt;
    rst_n = 1'b1;
    repeat (12) tick();
    check32("t1_throughput", 32'(pop_cnt - p0), 32'd10);
    end_test("t1");

    // T2: decode stalled, credit limit of 4, then resume in order
    lat = 1;
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) req_exp_q.push_back(32'(i * 4));
    r0 = req_cnt;
    rst_n = 1'b1;
    repeat (10) tick();
    check32("t2_req_count", 32'(req_cnt - r0), 32'd4);
    check32("t2_full_req_valid", 32'(s_req_valid), 32'd0);
    check32("t2_full_instr_valid", 32'(s_instr_valid), 32'd1);
    instr_ready = 1'b1;
    run_until_pops(6, 30);
    end_test("t2");

    // T3: 3-cycle memory, redirect with two requests in flight
    lat = 3;
    instr_ready = 1'b1;
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0104);
    exp_q.push_back(32'h0000_0108);
    exp_q.push_back(32'h0000_010C);
    req_exp_q.push_back(32'h0000_0000);
    req_exp_q.push_back(32'h0000_0004);
    req_exp_q.push_back(32'h0000_0100);
    req_exp_q.push_back(32'h0000_0104);
    rst_n = 1'b1;
    repeat (2) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    check32("t3_redirect_no_req", 32'(s_req_valid), 32'd0);
    redirect = 1'b0;
    run_until_pops(4, 40);
    end_test("t3");

    // T4: redirect coinciding with a response and a pop
    lat = 2;
    instr_ready = 1'b1;
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0000_0204);
    exp_q.push_back(32'h0000_0208);
    req_exp_q.push_back(32'h0000_0000);
    req_exp_q.push_back(32'h0000_0004);
    req_exp_q.push_back(32'h0000_0008);
    req_exp_q.push_back(32'h0000_0200);
    req_exp_q.push_back(32'h0000_0204);
    rst_n = 1'b1;
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    check32("t4_pop_at_redirect", 32'(s_instr_valid), 32'd1);
    redirect = 1'b0;
    tick();
    check32("t4_empty_after", 32'(s_instr_valid), 32'd0);
    run_until_pops(3, 40);
    end_test("t4");

    // T5: fetch address wraps past the top of memory
    lat = 1;
    instr_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    req_exp_q.push_back(32'h0000_0000);
    req_exp_q.push_back(32'hFFFF_FFF8);
    req_exp_q.push_back(32'hFFFF_FFFC);
    req_exp_q.push_back(32'h0000_0000);
    req_exp_q.push_back(32'h0000_0004);
    rst_n = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    run_until_pops(4, 30);
    end_test("t5");

    // T6: misaligned redirect target
    lat = 1;
    instr_ready = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    req_exp_q.push_back(32'h0000_0000);
    rst_n = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    r0 = req_cnt;
    tick();
    check32("t6_misalign_set", 32'(s_misalign), 32'd1);
    repeat (7) tick();
    check32("t6_halt_no_req", 32'(req_cnt - r0), 32'd0);
    check32("t6_halt_req_valid", 32'(s_req_valid), 32'd0);
    check32("t6_misalign_sticky", 32'(s_misalign), 32'd1);
`else
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0104);
    req_exp_q.push_back(32'h0000_0000);
    req_exp_q.push_back(32'h0000_0100);
    rst_n = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    run_until_pops(2, 30);
    check32("t6_misalign_clear", 32'(s_misalign), 32'd0);
`endif
    end_test("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the control unit and decode. Holds the fetch PC, issues word requests to instruction memory over a valid/ready handshake, buffers returned instructions with their PCs in an in-order queue, and presents opcode/funct3/funct7 plus the full word to decode. A redirect, driven by the control path's `pcsrc` and the computed target, flushes the buffer and all in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, instruction buffer entries and maximum in-flight requests; power of two, ≥2
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address (bits [1:0] always 0)
- `imem_rsp_valid`  in  1  response valid; in request order, no backpressure
- `imem_rsp_data`  in  32  instruction word
- `redirect`  in  1  take branch/jump (from `pcsrc`)
- `redirect_pc`  in  32  new fetch address
- `instr_valid`  out  1  head of buffer valid
- `instr_ready`  in  1  decode consumes head
- `instr`  out  32  instruction word
- `instr_pc`  out  32  PC of `instr`
- `opcode`  out  7  `instr[6:0]`
- `funct3`  out  3  `instr[14:12]`
- `funct7`  out  7  `instr[31:25]`
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch PC `fpc`; in-flight PC queue (DEPTH); instruction buffer of {instr, pc} (DEPTH); counters `outstanding`, `count`, `drop` (each $clog2(DEPTH)+1 bits).
- `imem_req_valid` = !redirect & !halted & (count + outstanding < DEPTH); `imem_req_addr` = `fpc`.
- Request handshake: push `fpc` to PC queue, `outstanding`+1, `fpc` += 4 (32-bit wrap, 32'hFFFF_FFFC → 0).
- Response with `drop`>0: discard, `drop`−1, `outstanding`−1, pop PC queue.
- Response with `drop`=0: pop PC queue, push {data, pc} into buffer, `outstanding`−1.
- Pop: `instr_valid & instr_ready` removes head.
- Redirect: `fpc` ← {redirect_pc[31:2], 2'b00}; buffer emptied (`count` ← 0); `drop` ← `outstanding` minus any response arriving this cycle (that response is itself discarded). A pop in the same cycle is honored before flush. Redirect while `drop`>0 recomputes `drop` the same way.
- Decoded fields are pure slices of `instr`; undefined when `instr_valid`=0.
- Credit rule guarantees no buffer overflow; responses never stalled.

## Timing
- Reset (rst_n low at posedge): `fpc`=RESET_PC, all counters 0, queues empty, `misalign_err`=0. While rst_n is low: `imem_req_valid`=0, `instr_valid`=0. Reset mid-operation discards everything in flight; responses arriving after release are not expected (memory is reset together).
- First request cycle after rst_n rises: `imem_req_addr`=RESET_PC.
- Response at cycle R → `instr_valid` at R+1 (registered, no bypass).
- Redirect at cycle N: no request at N; request to target at N+1 if ready.
- No combinational path `instr_ready`→`imem_req_valid`; throughput 1 instr/cycle with 1-cycle memory and DEPTH≥4.
- Full: count+outstanding=DEPTH → req_valid low. Empty: `instr_valid` low.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `misalign_err` (sticky until reset), flushes as a normal redirect, and sets `halted` (no further requests until reset).
- Undefined: `misalign_err` tied 0, bits [1:0] silently cleared, no halt.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory, ready always high → requests 0,4,8,…; `instr_pc` 0,4,8 on consecutive cycles from cycle 3, one per cycle.
- `instr_ready` low for 10 cycles → exactly DEPTH=4 requests issued, then `imem_req_valid` low; resume → order 0,4,8,12,16 preserved.
- 3-cycle memory latency, redirect to 0x100 with 2 in flight → both stale responses dropped; next `instr_pc`=0x100.
- Redirect in same cycle as a response and a pop → popped instr consumed, response discarded, buffer empty next cycle, `drop`= remaining outstanding.
- `fpc`=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With macro, redirect_pc=0x102 → `misalign_err`=1 next cycle, no further requests; without macro → fetch from 0x100.
